// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Contents: FSM state encoding, active-low seven-segment patterns for digits 0-9,
// the blank pattern, and a helper giving the minimum digit count for a width.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Active-low patterns, bit0=a ... bit6=g, bit7=dp (dp always off).
    localparam logic [7:0] Seg0     = 8'hC0;
    localparam logic [7:0] Seg1     = 8'hF9;
    localparam logic [7:0] Seg2     = 8'hA4;
    localparam logic [7:0] Seg3     = 8'hB0;
    localparam logic [7:0] Seg4     = 8'h99;
    localparam logic [7:0] Seg5     = 8'h92;
    localparam logic [7:0] Seg6     = 8'h82;
    localparam logic [7:0] Seg7     = 8'hF8;
    localparam logic [7:0] Seg8     = 8'h80;
    localparam logic [7:0] Seg9     = 8'h90;
    localparam logic [7:0] SegBlank = 8'hFF;

    // ceil(width * log10(2)) using a fixed-point approximation of log10(2).
    function automatic int unsigned min_digits(input int unsigned width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake/result bundle for bin_to_bcd_seq.
// start/bin : request and operand (driven by master)
// busy/done : status, done is a one-cycle pulse (driven by slave)
// bcd/seg   : packed BCD digits and active-low segment bytes, digit 0 lowest
interface bin_to_bcd_seq_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [8*DIGITS-1:0]   seg;

    modport master (output start, output bin, input busy, input done, input bcd, input seg);
    modport slave  (input start, input bin, output busy, output done, output bcd, output seg);
endinterface

// File: rtl/bin_to_bcd_seq_seg7_enc.sv
// Combinational BCD digit to active-low seven-segment encoder.
// digit_i : 4-bit digit code
// seg_o   : active-low pattern (bit0=a .. bit6=g, bit7=dp); codes 10-15 blank
module seg7_enc
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);
    always_comb begin
        seg_o = SegBlank;
        unique case (digit_i)
            4'd0:    seg_o = Seg0;
            4'd1:    seg_o = Seg1;
            4'd2:    seg_o = Seg2;
            4'd3:    seg_o = Seg3;
            4'd4:    seg_o = Seg4;
            4'd5:    seg_o = Seg5;
            4'd6:    seg_o = Seg6;
            4'd7:    seg_o = Seg7;
            4'd8:    seg_o = Seg8;
            4'd9:    seg_o = Seg9;
            default: seg_o = SegBlank;
        endcase
    end
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with seven-segment outputs.
// sysCLK : clock, rising edge
// RST    : asynchronous active-high reset
// bus    : slave side of bin_to_bcd_seq_if (start/bin in; busy/done/bcd/seg out)
// A conversion takes WIDTH shift cycles plus one DONE cycle; bcd/seg are
// registered and change on the edge that raises done.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DIGITS   = 5,
    parameter int unsigned BLANK_LZ = 1
) (
    input logic            sysCLK,
    input logic            RST,
    bin_to_bcd_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned AccW = 4 * DIGITS;
    localparam int unsigned SegW = 8 * DIGITS;

    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end

    state_e            state_q, state_d;
    logic [AccW-1:0]   acc_q, acc_d, acc_adj, acc_shift;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AccW-1:0]   bcd_q, bcd_d;
    logic [SegW-1:0]   seg_q, seg_d, seg_raw, seg_enc, seg_rst;
    logic              nz;

    // Add-3 correction followed by the combined {acc, bin} left shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end
    assign acc_shift = {acc_adj[AccW-2:0], bin_q[WIDTH-1]};

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_enc
        seg7_enc u_seg7_enc (
            .digit_i(acc_shift[4*g +: 4]),
            .seg_o  (seg_raw[8*g +: 8])
        );
        assign seg_rst[8*g +: 8] = (g == 0 || BLANK_LZ == 0) ? Seg0 : SegBlank;
    end

    // Blank every digit above the most significant non-zero one; units never blank.
    always_comb begin
        seg_enc = '0;
        nz      = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            nz = nz | (|acc_shift[4*i +: 4]);
            seg_enc[8*i +: 8] = (BLANK_LZ == 0 || i == 0 || nz) ? seg_raw[8*i +: 8] : SegBlank;
        end
    end

    // State register
    always_ff @(posedge sysCLK or posedge RST) begin
        if (RST) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StShift;
            StShift: if (cnt_q == CntW'(1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy = (state_q != StIdle);
        bus.done = (state_q == StDone);
        bus.bcd  = bcd_q;
        bus.seg  = seg_q;
    end

    // Datapath next-state
    always_comb begin
        acc_d = acc_q;
        bin_d = bin_q;
        cnt_d = cnt_q;
        bcd_d = bcd_q;
        seg_d = seg_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    bin_d = bus.bin;
                    acc_d = '0;
                    cnt_d = CntW'(WIDTH);
                end
            end
            StShift: begin
                acc_d = acc_shift;
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    bcd_d = acc_shift;
                    seg_d = seg_enc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysCLK or posedge RST) begin
        if (RST) begin
            acc_q <= '0;
            bin_q <= '0;
            cnt_q <= '0;
            bcd_q <= '0;
            seg_q <= seg_rst;
        end else begin
            acc_q <= acc_d;
            bin_q <= bin_d;
            cnt_q <= cnt_d;
            bcd_q <= bcd_d;
            seg_q <= seg_d;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: two instances (leading-zero blanking on
// and off) share stimulus and are compared every cycle against a decimal model.
module tb_bin_to_bcd_seq;
    localparam int unsigned W = 16;
    localparam int unsigned D = 5;
    localparam logic [7:0] PAT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                       8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic clk;
    logic rst;
    logic start;
    logic [W-1:0] bin;
    int total = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    bin_to_bcd_seq_if #(.WIDTH(W), .DIGITS(D)) if1 ();
    bin_to_bcd_seq_if #(.WIDTH(W), .DIGITS(D)) if0 ();
    assign if1.start = start;
    assign if1.bin   = bin;
    assign if0.start = start;
    assign if0.bin   = bin;

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(1)) dut (
        .sysCLK(clk), .RST(rst), .bus(if1)
    );
    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(0)) dut_nb (
        .sysCLK(clk), .RST(rst), .bus(if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [39:0] ref_seg(input int unsigned v, input bit blank);
        logic [39:0] r;
        int d [5];
        int msd;
        msd = 0;
        for (int i = 0; i < 5; i++) begin
            d[i] = int'(v % 10);
            v = v / 10;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < 5; i++) r[8*i +: 8] = (blank && i > msd) ? 8'hFF : PAT[d[i]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: phase 0 idle, 1..W shifting, W+1 done.
    int unsigned m_phase;
    int unsigned m_val;
    logic [19:0] m_bcd;
    logic [39:0] m_seg, m_seg_nb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  <= 0;
            m_bcd    <= '0;
            m_seg    <= ref_seg(0, 1'b1);
            m_seg_nb <= ref_seg(0, 1'b0);
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_val   <= bin;
            end
        end else if (m_phase == W) begin
            m_phase  <= W + 1;
            m_bcd    <= ref_bcd(m_val);
            m_seg    <= ref_seg(m_val, 1'b1);
            m_seg_nb <= ref_seg(m_val, 1'b0);
        end else if (m_phase == W + 1) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",    64'(if1.busy), 64'(m_phase != 0));
            chk("done",    64'(if1.done), 64'(m_phase == W + 1));
            chk("bcd",     64'(if1.bcd),  64'(m_bcd));
            chk("seg",     64'(if1.seg),  64'(m_seg));
            chk("nb_busy", 64'(if0.busy), 64'(m_phase != 0));
            chk("nb_done", 64'(if0.done), 64'(m_phase == W + 1));
            chk("nb_bcd",  64'(if0.bcd),  64'(m_bcd));
            chk("nb_seg",  64'(if0.seg),  64'(m_seg_nb));
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (if1.busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_reached", 64'(if1.busy), 64'(0));
    endtask

    // Pulse start with v; returns edges counted from start assertion to done visible.
    task automatic convert(input logic [W-1:0] v, input bit noise, output int edges);
        @(posedge clk);
        #1;
        bin   = v;
        start = 1'b1;
        edges = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        while (!if1.done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (!if1.done && noise) begin
                bin   = W'($urandom);
                start = ($urandom_range(0, 3) == 0);
            end
        end
        start = 1'b0;
        chk("done_seen", 64'(if1.done), 64'(1));
    endtask

    initial begin
        int e;
        int last;
        int ndone;
        int dones [$];
        rst   = 1'b0;
        start = 1'b0;
        bin   = '0;
        #2 rst = 1'b1;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(if1.busy), 64'(0));
        chk("rst_done", 64'(if1.done), 64'(0));
        chk("rst_bcd",  64'(if1.bcd),  64'(20'h00000));
        chk("rst_seg",  64'(if1.seg),  64'(40'hFF_FF_FF_FF_C0));
        chk("rst_seg_nb", 64'(if0.seg), 64'(40'hC0_C0_C0_C0_C0));
        rst = 1'b0;

        convert(16'd1234, 1'b0, e);
        chk("lat_1234", 64'(e), 64'(17));
        chk("bcd_1234", 64'(if1.bcd), 64'(20'h01234));
        chk("seg_1234", 64'(if1.seg), 64'(40'hFF_F9_A4_B0_99));
        chk("seg_nb_1234", 64'(if0.seg), 64'(40'hC0_F9_A4_B0_99));
        wait_idle();
        convert(16'd65535, 1'b0, e);
        chk("bcd_max", 64'(if1.bcd), 64'(20'h65535));
        chk("seg_max", 64'(if1.seg), 64'(40'h82_92_92_B0_92));
        wait_idle();
        convert(16'd0, 1'b0, e);
        chk("bcd_zero", 64'(if1.bcd), 64'(20'h00000));
        chk("seg_zero", 64'(if1.seg), 64'(40'hFF_FF_FF_FF_C0));
        wait_idle();

        // Second start at busy cycle 5 and a bin change must not disturb 100.
        @(posedge clk);
        #1;
        bin = 16'd100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin = 16'd777;
        repeat (4) @(posedge clk);
        #1;
        bin = 16'd999;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 0;
        while (!if1.done && e < 40) begin
            @(posedge clk);
            #1;
            e++;
        end
        chk("hs_bcd", 64'(if1.bcd), 64'(20'h00100));
        repeat (3) @(posedge clk);
        #1;
        chk("hs_no_queue", 64'(if1.busy), 64'(0));

        // Start held high: done every W+2 cycles.
        start = 1'b1;
        for (int c = 0; c < 75; c++) begin
            @(posedge clk);
            #1;
            bin = W'($urandom);
            if (if1.done) dones.push_back(c);
        end
        start = 1'b0;
        chk("held_count", 64'(dones.size() >= 3), 64'(1));
        for (int i = 1; i < dones.size(); i++)
            chk("held_period", 64'(dones[i] - dones[i-1]), 64'(18));
        wait_idle();

        // Reset at shift cycle 8 aborts without done.
        @(posedge clk);
        #1;
        bin = 16'd4321;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_busy", 64'(if1.busy), 64'(0));
        chk("mid_done", 64'(if1.done), 64'(0));
        chk("mid_bcd",  64'(if1.bcd),  64'(20'h00000));
        chk("mid_seg",  64'(if1.seg),  64'(40'hFF_FF_FF_FF_C0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (if1.done) ndone++;
        end
        chk("mid_no_done", 64'(ndone), 64'(0));
        convert(16'd9, 1'b0, e);
        chk("post_rst_bcd", 64'(if1.bcd), 64'(20'h00009));
        chk("post_rst_seg0", 64'(if1.seg[7:0]), 64'(8'h90));
        wait_idle();

        // Random conversions with gaps, bin changes and ignored start pulses.
        for (int k = 0; k < 150; k++) begin
            logic [W-1:0] v;
            unique case (k)
                0: v = 16'd10;
                1: v = 16'd9999;
                2: v = 16'd10000;
                3: v = 16'd65535;
                default: v = W'($urandom);
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk);
            convert(v, 1'b1, e);
            chk("rnd_lat", 64'(e), 64'(17));
            last = e;
            wait_idle();
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
